// File: rtl/aes_enc_stream_if.sv
// aes_enc_stream_if: word-serial pack/launch/capture/drain wrapper around the iterative AES-128 core.
// Input block, key and output block are all registered so the core sees only flop-driven signals.
module aes_enc_stream_if #(
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         key_v_i,
    input  logic [127:0] key_i,
    input  logic         in_v_i,
    output logic         in_ready_o,
    input  logic [31:0]  in_data_i,
    output logic         aes_data_v_o,
    output logic [127:0] aes_data_o,
    output logic [127:0] aes_key_o,
    input  logic         aes_res_v_i,
    input  logic [127:0] aes_res_i,
    output logic         out_v_o,
    input  logic         out_ready_i,
    output logic [31:0]  out_data_o,
    output logic         out_last_o,
    output logic         busy_o
);
    logic [2:0]   r_in_cnt;
    logic [1:0]   r_out_cnt;
    logic         r_out_full;
    logic         r_core_busy;
    logic [127:0] r_key_q;
    logic [127:0] r_in_buf;
    logic [127:0] r_out_buf;
    logic         w_in_full;
    logic         w_launch;
    logic         w_in_acc;
    logic         w_out_hs;
    logic         w_res;

    always_comb begin
        w_in_full = r_in_cnt == 3'(WORDS);
        w_launch  = w_in_full & ~r_core_busy & ~r_out_full;
        w_in_acc  = in_v_i & ~w_in_full;
        w_out_hs  = r_out_full & out_ready_i;
        w_res     = aes_res_v_i & r_core_busy;
    end

    assign in_ready_o   = ~w_in_full;
    assign aes_data_v_o = w_launch;
    assign aes_data_o   = r_in_buf;
    assign aes_key_o    = r_key_q;
    assign out_v_o      = r_out_full;
    // word 0 sits in the top 32 bits, so the slot index is the inverted count
    assign out_data_o   = r_out_buf[{~r_out_cnt, 5'd0} +: 32];
    assign out_last_o   = r_out_full & (r_out_cnt == 2'(WORDS - 1));
    assign busy_o       = r_core_busy;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_out_full  <= 1'b0;
            r_core_busy <= 1'b0;
            r_key_q     <= '0;
            r_in_buf    <= '0;
            r_out_buf   <= '0;
        end else begin
            if (key_v_i)
                r_key_q <= key_i;
            if (w_launch)
                r_in_cnt <= '0;
            else if (w_in_acc) begin
                r_in_buf[{~r_in_cnt[1:0], 5'd0} +: 32] <= in_data_i;
                r_in_cnt <= r_in_cnt + 3'd1;
            end
            if (w_launch)
                r_core_busy <= 1'b1;
            else if (aes_res_v_i)
                r_core_busy <= 1'b0;
            // the core presents its result for a single cycle only
            if (w_res) begin
                r_out_buf  <= aes_res_i;
                r_out_full <= 1'b1;
                r_out_cnt  <= '0;
            end else if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + 2'd1;
                if (r_out_cnt == 2'(WORDS - 1))
                    r_out_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_enc_stream_if.sv
// tb_aes_enc_stream_if: drives the stream wrapper against a behavioural 11-cycle AES-128 core
// and checks known-answer vectors, timing, backpressure, key timing, bubbles, reset and random traffic.
module tb_aes_enc_stream_if;
    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         key_v_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         in_v_i = 1'b0;
    logic         in_ready_o;
    logic [31:0]  in_data_i = '0;
    logic         aes_data_v_o;
    logic [127:0] aes_data_o;
    logic [127:0] aes_key_o;
    logic         aes_res_v_i;
    logic [127:0] aes_res_i;
    logic         out_v_o;
    logic         out_ready_i = 1'b0;
    logic [31:0]  out_data_o;
    logic         out_last_o;
    logic         busy_o;

    aes_enc_stream_if dut (
        .clk(clk), .nreset(nreset), .key_v_i(key_v_i), .key_i(key_i),
        .in_v_i(in_v_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .aes_data_v_o(aes_data_v_o), .aes_data_o(aes_data_o), .aes_key_o(aes_key_o),
        .aes_res_v_i(aes_res_v_i), .aes_res_i(aes_res_i),
        .out_v_o(out_v_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0, t_acc = 0, launch_cyc = -1, rise_cyc = -1, last_cyc = -1;
    logic out_v_prev = 1'b0;
    logic [7:0] sb [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [31:0] x;
        logic [7:0] rc = 8'h01;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            x = w[i-1];
            if (i % 4 == 0) begin
                x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ x;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*rd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = s[i];
        return r;
    endfunction

    // behavioural core: result pulse 11 cycles after the launch cycle, data only valid in that cycle
    logic [3:0]   core_cnt = '0;
    logic [127:0] core_res = '0;
    always @(posedge clk) begin
        if (!nreset) core_cnt <= '0;
        else if (aes_data_v_o) begin
            core_cnt <= 4'd11;
            core_res <= aes128(aes_key_o, aes_data_o);
        end else if (core_cnt != 0) core_cnt <= core_cnt - 4'd1;
    end
    assign aes_res_v_i = core_cnt == 4'd1;
    assign aes_res_i   = aes_res_v_i ? core_res : ~core_res;

    always @(negedge clk) begin
        if (aes_data_v_o) begin
            launch_cyc = cyc;
            chk("launch_vs_res", 128'(aes_res_v_i), 128'(0));
        end
        if (out_v_o && !out_v_prev) rise_cyc = cyc;
        out_v_prev = out_v_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_v_i = 1'b1;
        key_i = k;
        tick();
        key_v_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_v_i = 1'b1;
        in_data_i = w;
        while (!in_ready_o && n < 200) begin tick(); n++; end
        if (n == 200) chk("in_ready_timeout", 128'(in_ready_o), 128'(1));
        t_acc = cyc;
        tick();
        in_v_i = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] pt, input bit bubbles);
        for (int k = 0; k < 4; k++) begin
            if (bubbles) tick();
            send_word(pt[127 - 32*k -: 32]);
        end
    endtask

    task automatic recv_block(input logic [127:0] exp, input string tag);
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (!out_v_o && n < 200) begin tick(); n++; end
            if (n == 200) chk({tag, "_out_v_timeout"}, 128'(out_v_o), 128'(1));
            chk({tag, "_data"}, 128'(out_data_o), 128'(exp[127 - 32*k -: 32]));
            chk({tag, "_last"}, 128'(out_last_o), 128'(k == 3));
            if (k == 3) last_cyc = cyc;
            tick();
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin : main
        vec_t tbl [3];
        logic [31:0] in_q [$];
        logic [31:0] exp_q [$];
        logic [127:0] rkey, blk;
        int widx, n;
        bit seen;
        #200_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin : stim
        vec_t tbl [3];
        logic [31:0] in_q [$];
        logic [31:0] exp_q [$];
        logic [127:0] rkey, blk;
        int widx, n;
        bit seen;
        tbl[0] = '{KC1, PC1, CC1};
        tbl[1] = '{KB, PB, CB};
        tbl[2] = '{KB, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        build_sbox();
        repeat (3) tick();
        chk("rst_in_ready", 128'(in_ready_o), 128'(1));
        chk("rst_data_v", 128'(aes_data_v_o), 128'(0));
        chk("rst_out_v", 128'(out_v_o), 128'(0));
        chk("rst_last", 128'(out_last_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_key", aes_key_o, 128'(0));
        chk("rst_data", aes_data_o, 128'(0));
        nreset = 1'b1;
        tick();

        for (int v = 0; v < 3; v++) begin
            load_key(tbl[v].key);
            send_block(tbl[v].pt, 1'b0);
            recv_block(tbl[v].ct, "tbl");
            chk("tbl_launch_lat", 128'(launch_cyc), 128'(t_acc + 1));
            chk("tbl_out_v_lat", 128'(rise_cyc), 128'(t_acc + 13));
            chk("tbl_last_lat", 128'(last_cyc), 128'(t_acc + 16));
        end

        // backpressure with a second block waiting
        load_key(KC1);
        send_block(PC1, 1'b0);
        out_ready_i = 1'b0;
        send_block(PB, 1'b0);
        chk("bp_in_ready_full", 128'(in_ready_o), 128'(0));
        n = 0;
        while (!out_v_o && n < 100) begin tick(); n++; end
        chk("bp_out_v_rise", 128'(out_v_o), 128'(1));
        for (int k = 0; k < 20; k++) begin
            chk("bp_hold", 128'(out_data_o), 128'(32'h69c4e0d8));
            chk("bp_no_launch", 128'(aes_data_v_o), 128'(0));
            tick();
        end
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_no_launch_drain", 128'(aes_data_v_o), 128'(0));
            chk("bp_drain", 128'(out_data_o), 128'(CC1[127 - 32*k -: 32]));
            tick();
        end
        chk("bp_launch_after_drain", 128'(aes_data_v_o), 128'(1));
        recv_block(aes128(KC1, PB), "bp2");

        // key change in the launch cycle
        load_key(KC1);
        send_block(PC1, 1'b0);
        chk("kc_launch_now", 128'(aes_data_v_o), 128'(1));
        key_v_i = 1'b1;
        key_i = KB;
        tick();
        key_v_i = 1'b0;
        chk("kc_key_reg", aes_key_o, KB);
        recv_block(CC1, "kc_old");
        send_block(PB, 1'b0);
        recv_block(CB, "kc_new");

        send_block(PB, 1'b1);
        recv_block(CB, "bubble");

        // reset five cycles into the core run
        load_key(KC1);
        send_block(PC1, 1'b0);
        repeat (5) tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        chk("mr_busy", 128'(busy_o), 128'(0));
        chk("mr_in_ready", 128'(in_ready_o), 128'(1));
        chk("mr_out_v", 128'(out_v_o), 128'(0));
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            seen |= out_v_o;
            tick();
        end
        chk("mr_no_output", 128'(seen), 128'(0));
        load_key(KC1);
        send_block(PC1, 1'b0);
        recv_block(CC1, "mr_after");

        // random traffic against a block-level model
        rkey = {$urandom, $urandom, $urandom, $urandom};
        load_key(rkey);
        widx = 0;
        for (int c = 0; c < 900; c++) begin
            in_v_i = c < 800 && ($urandom % 2 == 1);
            in_data_i = $urandom;
            out_ready_i = ($urandom % 10) < 7;
            #1;
            if (in_v_i && in_ready_o) begin
                in_q.push_back(in_data_i);
                if (in_q.size() == 4) begin
                    blk = {in_q[0], in_q[1], in_q[2], in_q[3]};
                    in_q.delete();
                    blk = aes128(rkey, blk);
                    for (int k = 0; k < 4; k++) exp_q.push_back(blk[127 - 32*k -: 32]);
                end
            end
            if (out_v_o && out_ready_i) begin
                if (exp_q.size() == 0) chk("rnd_spurious", 128'(1), 128'(0));
                else begin
                    chk("rnd_data", 128'(out_data_o), 128'(exp_q.pop_front()));
                    chk("rnd_last", 128'(out_last_o), 128'(widx % 4 == 3));
                    widx++;
                end
            end
            tick();
        end
        chk("rnd_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
